// File: rtl/connector_stim_driver.sv
// connector_stim_driver
// Three-channel write-burst source for the connector top. A start request in
// IDLE launches a burst of burst_len beats on the channels selected by
// chan_mask. Beat data follows a deterministic pattern seeded at start.
// Consecutive beats are separated by GAP idle cycles.
//
// Optional feature (macro CONNECTOR_DRV_LFSR_EN):
//   undefined : pattern = seed, seed+1, ...     datak = pattern + k
//   defined   : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, shift left,
//               feedback into bit 0), zero seed replaced by 8'h01,
//               datak = pattern ^ k
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 burst request, sampled only in IDLE
//   chan_mask[2:0]        channel enables, latched at start
//   burst_len[BURST_W-1:0] beats per burst, latched at start
//   seed[7:0]             initial pattern value, latched at start
//   freeze                stalls RUN/GAP (state, counters, pattern), wen low
//   busy                  burst in flight (through the done cycle)
//   done                  one-cycle pulse at burst end
//   beat_cnt              beats emitted in the current or last burst
//   wen0..2, data0..2     registered per-channel strobe and data
//   dbg_state[1:0]        current FSM state (IDLE=0, RUN=1, GAP=2, DONE=3)
//
// Handshake: start is a request taken only while the block is idle; done
// pulses for exactly one cycle when the burst is over, and busy stays high
// from the cycle after start up to and including the done cycle, so a new
// start may be issued as soon as busy has dropped.
module connector_stim_driver #(
  parameter int BURST_W = 8,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         chan_mask,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [7:0]         seed,
  input  logic               freeze,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] beat_cnt,
  output logic               wen0,
  output logic               wen1,
  output logic               wen2,
  output logic [7:0]         data0,
  output logic [7:0]         data1,
  output logic [7:0]         data2,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t             state_q, state_d;
  logic [2:0]         mask_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] cnt_q;
  logic [BURST_W-1:0] cnt_inc;
  logic [7:0]         pat_q;
  logic [7:0]         pat_next;
  logic [7:0]         seed_eff;
  logic [3:0]         gap_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         wen_q, wen_d;
  logic [7:0]         data_q [3];
  logic [7:0]         data_d [3];
  logic               accept;
  logic               beat_fire;
  logic               last_beat;

  function automatic logic [7:0] chan_data(input logic [7:0] p, input logic [1:0] k);
`ifdef CONNECTOR_DRV_LFSR_EN
    return p ^ {6'd0, k};
`else
    return p + {6'd0, k};
`endif
  endfunction

`ifdef CONNECTOR_DRV_LFSR_EN
  assign pat_next = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
  // An all-zero LFSR would lock up, so a zero seed is nudged to 1.
  assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;
`else
  assign pat_next = pat_q + 8'd1;
  assign seed_eff = seed;
`endif

  assign accept    = (state_q == S_IDLE) && start;
  assign beat_fire = (state_q == S_RUN) && !freeze;
  assign cnt_inc   = cnt_q + 1'b1;
  // cnt_q < len_q always holds in RUN, so cnt_inc cannot wrap here.
  assign last_beat = beat_fire && (cnt_inc == len_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = ((chan_mask != 3'b000) && (burst_len != '0)) ? S_RUN : S_DONE;
      S_RUN: begin
        if (beat_fire) begin
          if (last_beat)    state_d = S_DONE;
          else if (GAP > 0) state_d = S_GAP;
        end
      end
      S_GAP:  if (!freeze && (gap_q == GAP_LAST)) state_d = S_RUN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (values registered below)
  always_comb begin
    wen_d  = 3'b000;
    data_d = data_q;
    for (int k = 0; k < 3; k++) begin
      // Disabled channels keep their last data so the bus only moves on strobes.
      if (beat_fire && mask_q[k]) begin
        wen_d[k]  = 1'b1;
        data_d[k] = chan_data(pat_q, 2'(k));
      end
    end
    done_d = (state_q == S_DONE);
    // Covers the done cycle too: the FSM is already back in IDLE then.
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= 3'b000;
      len_q  <= '0;
      cnt_q  <= '0;
      pat_q  <= 8'h00;
      gap_q  <= 4'd0;
      wen_q  <= 3'b000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < 3; k++) data_q[k] <= 8'h00;
    end else begin
      wen_q  <= wen_d;
      busy_q <= busy_d;
      done_q <= done_d;
      for (int k = 0; k < 3; k++) data_q[k] <= data_d[k];
      if (accept) begin
        mask_q <= chan_mask;
        len_q  <= burst_len;
        pat_q  <= seed_eff;
        cnt_q  <= '0;
      end else if (beat_fire) begin
        pat_q <= pat_next;
        if (cnt_q != len_q) cnt_q <= cnt_inc;
      end
      // The gap counter restarts on every beat and holds while frozen.
      if (beat_fire)                          gap_q <= 4'd0;
      else if ((state_q == S_GAP) && !freeze) gap_q <= gap_q + 4'd1;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign beat_cnt  = cnt_q;
  assign wen0      = wen_q[0];
  assign wen1      = wen_q[1];
  assign wen2      = wen_q[2];
  assign data0     = data_q[0];
  assign data1     = data_q[1];
  assign data2     = data_q[2];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_connector_stim_driver.sv
// Bench for connector_stim_driver: two instances (GAP=0 and GAP=2) share the
// same stimulus; each has its own monitor checking beat content, spacing,
// done/busy timing and beat_cnt against a burst-level model.
module tb_connector_stim_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       freeze;
  logic [2:0] chan_mask;
  logic [7:0] burst_len;
  logic [7:0] seed;

  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] cnt_w  [2];
  logic [2:0] wen_w  [2];
  logic [7:0] d_w    [2][3];
  logic [1:0] st_w   [2];

  int gv [2] = '{0, 2};

  always #5 clk = ~clk;

  connector_stim_driver #(.BURST_W(8), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .start(start), .chan_mask(chan_mask),
    .burst_len(burst_len), .seed(seed), .freeze(freeze),
    .busy(busy_w[0]), .done(done_w[0]), .beat_cnt(cnt_w[0]),
    .wen0(wen_w[0][0]), .wen1(wen_w[0][1]), .wen2(wen_w[0][2]),
    .data0(d_w[0][0]), .data1(d_w[0][1]), .data2(d_w[0][2]),
    .dbg_state(st_w[0])
  );

  connector_stim_driver #(.BURST_W(8), .GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .start(start), .chan_mask(chan_mask),
    .burst_len(burst_len), .seed(seed), .freeze(freeze),
    .busy(busy_w[1]), .done(done_w[1]), .beat_cnt(cnt_w[1]),
    .wen0(wen_w[1][0]), .wen1(wen_w[1][1]), .wen2(wen_w[1][2]),
    .data0(d_w[1][0]), .data1(d_w[1][1]), .data2(d_w[1][2]),
    .dbg_state(st_w[1])
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  logic [10:0] exp_q [$];          // expected beats: {mask, pattern}
  int          rd_idx [2];
  int          active [2];         // unfrozen edges since last beat/start
  int          exp_done_cyc [2];
  int          busy_chk [2];
  bit          got_done [2];
  logic [7:0]  prev_d [2][3];
  logic [7:0]  exp_cnt;
  int          neg_cnt = 0;
  logic        frz_at_edge;

  always @(posedge clk) frz_at_edge <= freeze;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_pat(input logic [7:0] p);
`ifdef CONNECTOR_DRV_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] beat_data(input logic [7:0] p, input int k);
`ifdef CONNECTOR_DRV_LFSR_EN
    return p ^ 8'(k);
`else
    return p + 8'(k);
`endif
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input int i);
    logic [10:0] b;
    logic [7:0]  ed [3];
    logic [2:0]  ew;
    if (!frz_at_edge) active[i]++;
    if (wen_w[i] != 3'b000) begin
      if (frz_at_edge) chk("wen_during_freeze", {29'd0, wen_w[i]}, 32'd0);
      if (rd_idx[i] >= exp_q.size()) begin
        chk("unexpected_beat", {29'd0, wen_w[i]}, 32'd0);
      end else begin
        b  = exp_q[rd_idx[i]];
        ew = b[10:8];
        for (int k = 0; k < 3; k++) begin
          ed[k] = ew[k] ? beat_data(b[7:0], k) : prev_d[i][k];
          prev_d[i][k] = ed[k];
        end
        chk("beat", {5'd0, wen_w[i], d_w[i][2], d_w[i][1], d_w[i][0]},
                    {5'd0, ew, ed[2], ed[1], ed[0]});
        chk("beat_spacing", active[i], (rd_idx[i] == 0) ? 2 : gv[i] + 1);
        active[i] = 0;
        rd_idx[i]++;
        if (rd_idx[i] == exp_q.size()) exp_done_cyc[i] = neg_cnt + 1;
      end
    end
    if (done_w[i] || (neg_cnt == exp_done_cyc[i])) begin
      chk("done_pulse", {done_w[i], wen_w[i]}, {(neg_cnt == exp_done_cyc[i]), 3'b000});
      chk("busy_at_done", busy_w[i], 1);
      chk("cnt_at_done", cnt_w[i], exp_cnt);
      got_done[i] = 1'b1;
      busy_chk[i] = neg_cnt + 1;
    end else if (neg_cnt == busy_chk[i]) begin
      chk("busy_after_done", {busy_w[i], done_w[i]}, 0);
    end
  endtask

  always @(negedge clk) begin
    neg_cnt++;
    for (int i = 0; i < 2; i++) mon(i);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      rd_idx[i] = 0;
      active[i] = 0;
      exp_done_cyc[i] = -1;
      busy_chk[i] = -1;
      got_done[i] = 1'b0;
      for (int k = 0; k < 3; k++) prev_d[i][k] = 8'h00;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_ctl"}, {busy_w[i], done_w[i], cnt_w[i], wen_w[i]}, 0);
      chk({name, "_data"}, {d_w[i][2], d_w[i][1], d_w[i][0]}, 0);
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    clear_model();
    freeze = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_burst(input logic [2:0] m, input logic [7:0] l, input logic [7:0] sd,
                           input int frz_at, input int frz_len, input bit rnd_frz,
                           input bit spur, input logic [7:0] exp_c, input int abort);
    logic [7:0] p;
    int  budget;
    int  frz_left;
    bit  frz_used;
    bit  aborted;
    @(negedge clk);
    freeze = 1'b0;
    budget = 0;
    while ((busy_w[0] || busy_w[1]) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) chk("idle_wait_timeout", 1, 0);
    exp_q.delete();
    if (m != 3'b000 && l != 8'd0) begin
      p = sd;
`ifdef CONNECTOR_DRV_LFSR_EN
      if (p == 8'h00) p = 8'h01;
`endif
      for (int j = 0; j < int'(l); j++) begin
        exp_q.push_back({m, p});
        p = next_pat(p);
      end
    end
    exp_cnt   = exp_c;
    chan_mask = m;
    burst_len = l;
    seed      = sd;
    start     = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      rd_idx[i] = 0;
      active[i] = 0;
      got_done[i] = 1'b0;
      busy_chk[i] = -1;
      exp_done_cyc[i] = (exp_q.size() == 0) ? neg_cnt + 2 : -1;
    end
    #1 start = 1'b0;
    budget = 0;
    frz_left = 0;
    frz_used = 1'b0;
    aborted = 1'b0;
    while (!(got_done[0] && got_done[1]) && budget < 3000 && !aborted) begin
      @(negedge clk);
      budget++;
      if (abort > 0 && rd_idx[0] >= abort) begin
        do_reset();
        aborted = 1'b1;
      end else begin
        if (spur && budget == 2) begin
          start = 1'b1;
          burst_len = l + 8'd3;
          seed = ~sd;
          chan_mask = 3'b111;
        end else begin
          start = 1'b0;
        end
        if (rnd_frz) begin
          freeze = ($urandom_range(0, 3) == 0);
        end else begin
          if (frz_len > 0 && !frz_used && rd_idx[0] >= frz_at) begin
            frz_used = 1'b1;
            frz_left = frz_len;
          end
          freeze = (frz_left > 0);
          if (frz_left > 0) frz_left--;
        end
      end
    end
    start  = 1'b0;
    freeze = 1'b0;
    if (!aborted) begin
      if (!(got_done[0] && got_done[1])) chk("burst_timeout", 0, 1);
      chk("all_beats_g0", rd_idx[0], exp_q.size());
      chk("all_beats_g2", rd_idx[1], exp_q.size());
      @(negedge clk);
      @(negedge clk);
      chk("cnt_hold_g0", cnt_w[0], exp_c);
      chk("cnt_hold_g2", cnt_w[1], exp_c);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] m;
    logic [7:0] l;
    logic [7:0] sd;
    int         frz_at;
    int         frz_len;
    bit         spur;
    logic [7:0] exp_c;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rm;
    logic [7:0] rl;
    reset = 1'b1;
    start = 1'b0;
    freeze = 1'b0;
    chan_mask = 3'b000;
    burst_len = 8'd0;
    seed = 8'h00;
    clear_model();
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    tbl[0] = '{3'b111, 8'd4, 8'h10, 0, 0, 1'b0, 8'd4};
    tbl[1] = '{3'b010, 8'd3, 8'hFE, 0, 0, 1'b0, 8'd3};
    tbl[2] = '{3'b111, 8'd6, 8'h00, 2, 5, 1'b0, 8'd6};
    tbl[3] = '{3'b000, 8'd5, 8'h33, 0, 0, 1'b0, 8'd0};
    tbl[4] = '{3'b101, 8'd7, 8'h80, 0, 0, 1'b1, 8'd7};
    tbl[5] = '{3'b011, 8'd0, 8'h20, 0, 0, 1'b0, 8'd0};
    tbl[6] = '{3'b100, 8'd1, 8'hFF, 0, 0, 1'b0, 8'd1};
    for (int v = 0; v < 7; v++)
      run_burst(tbl[v].m, tbl[v].l, tbl[v].sd, tbl[v].frz_at, tbl[v].frz_len,
                1'b0, tbl[v].spur, tbl[v].exp_c, 0);

`ifdef CONNECTOR_DRV_LFSR_EN
    run_burst(3'b001, 8'd3, 8'h00, 0, 0, 1'b0, 1'b0, 8'd3, 0);
`endif

    for (int r = 0; r < 20; r++) begin
      rm = 3'($urandom_range(0, 7));
      rl = 8'($urandom_range(0, 12));
      run_burst(rm, rl, 8'($urandom_range(0, 255)), 0, 0, 1'b1, 1'b0,
                (rm != 3'b000 && rl != 8'd0) ? rl : 8'd0, 0);
    end

    // Reset during beat 3 of 8, then verify the block idles and restarts cleanly.
    run_burst(3'b111, 8'd8, 8'h40, 0, 0, 1'b0, 1'b0, 8'd8, 3);
    repeat (5) @(negedge clk);
    chk("idle_after_reset_g0", {busy_w[0], cnt_w[0]}, 0);
    chk("idle_after_reset_g2", {busy_w[1], cnt_w[1]}, 0);
    run_burst(3'b011, 8'd3, 8'h77, 0, 0, 1'b0, 1'b0, 8'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
